spi_mem_slave: RTL and testbench
================================

// Module: spi_mem_slave
// PURPOSE
//  SPI-slave byte memory answering the SoC's spi_master (mode 0, MSB first, CS active-low).
//  Decodes READ (0x03) and WRITE (0x02) commands, each followed by a 16-bit address and
//  streamed data bytes. Used as on-chip/FPGA stand-in for external instruction/data SRAM.
//  Has a parallel loader port to preload program images before the core leaves reset.
// PARAMETERS
//  DEPTH      256   bytes of storage; AW = $clog2(DEPTH); address bits above AW ignored
//  CMD_READ   8'h03 read opcode
//  CMD_WRITE  8'h02 write opcode
// PORTS
//  clk_core_i   in   1      core clock; SPI inputs oversampled on this clock
//  rst_n_i      in   1      asynchronous, active-low reset
//  spi_sclk_i   in   1      SPI clock from master, idle low
//  spi_cs_i     in   1      chip select, active low
//  spi_mosi_i   in   1      master-out data
//  spi_miso_o   out  1      slave-out data
//  ld_we_i      in   1      loader write strobe
//  ld_addr_i    in   AW     loader byte address
//  ld_data_i    in   8      loader write data
//  busy_o       out  1      high while synchronized CS is asserted
//  cmd_err_o    out  1      one-cycle pulse on unsupported opcode
// BEHAVIOUR
//  - sclk, cs, mosi pass 2-FF synchronizers; edges detected on clk_core_i (3-cycle lag).
//  - Requirement: SCLK high and low phases each >= 4 clk_core_i cycles.
//  - Reset: state IDLE, bit_cnt 0, addr 0, rx/tx shift 0; spi_miso_o=0, busy_o=0,
//    cmd_err_o=0. Memory array is not reset.
//  - MOSI sampled on detected SCLK rising edge into rx_shift; bit_cnt (3b) increments, wraps at 8.
//  - FSM: IDLE -> CMD on CS falling. CMD: after 8 bits, opcode READ/WRITE -> ADDR_HI,
//    otherwise pulse cmd_err_o -> IGNORE. ADDR_HI -> ADDR_LO after 8 bits.
//    ADDR_LO after 8 bits: addr = {hi,lo}[AW-1:0]; READ -> DATA_RD, WRITE -> DATA_WR.
//  - Any state: CS deassert (synced) -> IDLE in that cycle; partial byte dropped, no write.
//  - DATA_WR: on 8th bit, mem[addr] <= rx byte, addr <= addr+1 mod DEPTH.
//  - DATA_RD: entry cycle loads tx_shift <= mem[addr], addr++ (before master's next rising
//    edge). Each falling edge shifts tx_shift left; falling edge after a byte's 8th bit
//    reloads tx_shift <= mem[addr], addr++. Unlimited burst, wraps at DEPTH-1 -> 0.
//  - spi_miso_o = tx_shift[7] in DATA_RD, else 0 (no tristate).
//  - Loader: ld_we_i writes mem[ld_addr_i] any time; same-cycle collision with an SPI
//    write to the same address: loader wins, SPI byte lost; address still increments.
//  - Async reset mid-transfer aborts; next transfer needs fresh CS falling edge.
// CONFIGURATION
//  SPI_MEM_WP_EN defined: adds input wp_n_i (1b, active-low write protect); while low,
//    DATA_WR bytes are discarded (addr still increments); loader port is unaffected.
//  Undefined: no wp_n_i port; all SPI writes commit.
// TESTING
//  1 Load 0xA5 at 0x10 via loader; SPI 03 00 10 + 1 dummy byte -> MISO returns 0xA5.
//  2 SPI 02 00 20 11 22 then 03 00 20 xx xx -> reads 0x11,0x22; addr 0x21 holds 0x22.
//  3 DEPTH=256: write 02 00 FF 5A 6B -> mem[0xFF]=0x5A, mem[0x00]=0x6B (wrap).
//  4 Opcode 0x9F -> cmd_err_o one pulse, MISO 0, memory unchanged until CS high.
//  5 CS high after 5 data bits of a write to 0x30 -> mem[0x30] unchanged, busy_o drops.
//  6 SPI_MEM_WP_EN, wp_n_i=0: 02 00 40 77 -> mem[0x40] unchanged; wp_n_i=1 -> 0x77 written.

Source files
------------

// File: rtl/spi_mem_slave_if.sv
// SPI pin bundle between the SoC spi_master and spi_mem_slave.
// Member names match the slave-side pin names.
interface spi_mem_slave_if;
    logic spi_sclk_i;
    logic spi_cs_i;
    logic spi_mosi_i;
    logic spi_miso_o;

    modport master (
        output spi_sclk_i,
        output spi_cs_i,
        output spi_mosi_i,
        input  spi_miso_o
    );

    modport slave (
        input  spi_sclk_i,
        input  spi_cs_i,
        input  spi_mosi_i,
        output spi_miso_o
    );
endinterface

// File: rtl/spi_mem_slave.sv
// SPI mode-0 slave byte memory (READ 0x03 / WRITE 0x02, 16-bit address, streamed data)
// with a parallel preload port. Optional write protect input is enabled by SPI_MEM_WP_EN.
module spi_mem_slave #(
    parameter int         DEPTH     = 256,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02,
    localparam int        AW        = $clog2(DEPTH)
) (
    input  logic          clk_core_i,
    input  logic          rst_n_i,
    spi_mem_slave_if.slave spi,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [7:0]    ld_data_i,
`ifdef SPI_MEM_WP_EN
    input  logic          wp_n_i,
`endif
    output logic          busy_o,
    output logic          cmd_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_ADDR_LO = 3'd3,
        ST_DATA_RD = 3'd4,
        ST_DATA_WR = 3'd5,
        ST_IGNORE  = 3'd6
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [2:0]    sclk_sync_r, cs_sync_r, cs_vld_r;
    logic [1:0]    mosi_sync_r;
    logic [2:0]    bit_cnt_r;
    logic [6:0]    rx_shift_r;
    logic [7:0]    tx_shift_r, addr_hi_r;
    logic [AW-1:0] addr_r;
    logic          is_read_r, rd_entry_r, rd_skip_r;
    logic          miso_r, busy_r, cmd_err_r;
    logic [7:0]    mem_r [DEPTH];

    logic          sclk_rise_s, sclk_fall_s, cs_fall_s, cs_high_s, byte_done_s, wp_ok_s;
    logic [7:0]    rx_byte_s, mem_rd_s;
    logic          cmd_err_s, cmd_ok_s, cmd_rd_s, addr_hi_ld_s, addr_ld_s, spi_we_s;
    logic          addr_inc_s, tx_load_s, tx_shift_en_s, skip_clr_s;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (a == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return a + {{(AW-1){1'b0}}, 1'b1};
        end
    endfunction

`ifdef SPI_MEM_WP_EN
    assign wp_ok_s = wp_n_i;
`else
    assign wp_ok_s = 1'b1;
`endif

    // cs_vld_r masks the edge detector until reset values have left the CS chain,
    // so a CS held low across reset never looks like a fresh select.
    assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign cs_high_s   = cs_sync_r[1];
    assign cs_fall_s   = ~cs_sync_r[1] & cs_sync_r[2] & cs_vld_r[2];
    assign rx_byte_s   = {rx_shift_r, mosi_sync_r[1]};
    assign byte_done_s = sclk_rise_s && (bit_cnt_r == 3'd7);
    assign mem_rd_s    = mem_r[addr_r];

    // Input synchronizers and one-cycle-delayed copies for edge detection.
    always_ff @(posedge clk_core_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 3'b111;
            cs_vld_r    <= 3'b000;
            mosi_sync_r <= 2'b00;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], spi.spi_sclk_i};
            cs_sync_r   <= {cs_sync_r[1:0], spi.spi_cs_i};
            cs_vld_r    <= {cs_vld_r[1:0], 1'b1};
            mosi_sync_r <= {mosi_sync_r[0], spi.spi_mosi_i};
        end
    end

    // Next-state and datapath strobes; CS release overrides every state.
    always_comb begin
        state_nxt_s   = state_r;
        cmd_err_s     = 1'b0;
        cmd_ok_s      = 1'b0;
        cmd_rd_s      = 1'b0;
        addr_hi_ld_s  = 1'b0;
        addr_ld_s     = 1'b0;
        spi_we_s      = 1'b0;
        addr_inc_s    = 1'b0;
        tx_load_s     = 1'b0;
        tx_shift_en_s = 1'b0;
        skip_clr_s    = 1'b0;
        if (cs_high_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) state_nxt_s = ST_CMD;
                    else           state_nxt_s = ST_IDLE;
                end
                ST_CMD: begin
                    if (byte_done_s) begin
                        if (rx_byte_s == CMD_READ || rx_byte_s == CMD_WRITE) begin
                            state_nxt_s = ST_ADDR_HI;
                            cmd_ok_s    = 1'b1;
                            cmd_rd_s    = (rx_byte_s == CMD_READ);
                        end else begin
                            state_nxt_s = ST_IGNORE;
                            cmd_err_s   = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_CMD;
                    end
                end
                ST_ADDR_HI: begin
                    if (byte_done_s) begin
                        state_nxt_s  = ST_ADDR_LO;
                        addr_hi_ld_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_ADDR_HI;
                    end
                end
                ST_ADDR_LO: begin
                    if (byte_done_s) begin
                        addr_ld_s = 1'b1;
                        if (is_read_r) state_nxt_s = ST_DATA_RD;
                        else           state_nxt_s = ST_DATA_WR;
                    end else begin
                        state_nxt_s = ST_ADDR_LO;
                    end
                end
                ST_DATA_WR: begin
                    if (byte_done_s) begin
                        addr_inc_s = 1'b1;
                        spi_we_s   = wp_ok_s;
                    end else begin
                        state_nxt_s = ST_DATA_WR;
                    end
                end
                // The first falling edge after entry closes the address byte; MISO
                // already holds the preloaded MSB, so that edge is skipped.
                ST_DATA_RD: begin
                    if (rd_entry_r) begin
                        tx_load_s  = 1'b1;
                        addr_inc_s = 1'b1;
                    end else if (sclk_fall_s) begin
                        if (rd_skip_r) begin
                            skip_clr_s = 1'b1;
                        end else if (bit_cnt_r == 3'd0) begin
                            tx_load_s  = 1'b1;
                            addr_inc_s = 1'b1;
                        end else begin
                            tx_shift_en_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_DATA_RD;
                    end
                end
                ST_IGNORE: state_nxt_s = ST_IGNORE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register, shifters, address counter and registered outputs.
    always_ff @(posedge clk_core_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 3'd0;
            rx_shift_r <= 7'd0;
            tx_shift_r <= 8'd0;
            addr_hi_r  <= 8'd0;
            addr_r     <= {AW{1'b0}};
            is_read_r  <= 1'b0;
            rd_entry_r <= 1'b0;
            rd_skip_r  <= 1'b0;
            miso_r     <= 1'b0;
            busy_r     <= 1'b0;
            cmd_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cmd_err_r  <= cmd_err_s;
            busy_r     <= ~cs_sync_r[1];
            miso_r     <= (state_r == ST_DATA_RD) ? tx_shift_r[7] : 1'b0;
            rd_entry_r <= addr_ld_s & is_read_r;

            if (state_r == ST_IDLE || cs_high_s) begin
                bit_cnt_r  <= 3'd0;
                rx_shift_r <= 7'd0;
            end else if (sclk_rise_s) begin
                bit_cnt_r  <= bit_cnt_r + 3'd1;
                rx_shift_r <= rx_byte_s[6:0];
            end else begin
                bit_cnt_r  <= bit_cnt_r;
                rx_shift_r <= rx_shift_r;
            end

            if (cmd_ok_s)          is_read_r <= cmd_rd_s;
            else                   is_read_r <= is_read_r;

            if (addr_hi_ld_s)      addr_hi_r <= rx_byte_s;
            else                   addr_hi_r <= addr_hi_r;

            if (addr_ld_s)         addr_r <= AW'({addr_hi_r, rx_byte_s});
            else if (addr_inc_s)   addr_r <= next_addr(addr_r);
            else                   addr_r <= addr_r;

            if (addr_ld_s && is_read_r) rd_skip_r <= 1'b1;
            else if (skip_clr_s)        rd_skip_r <= 1'b0;
            else                        rd_skip_r <= rd_skip_r;

            if (tx_load_s)         tx_shift_r <= mem_rd_s;
            else if (tx_shift_en_s) tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            else                   tx_shift_r <= tx_shift_r;
        end
    end

    // Storage array (not reset); the loader wins a same-address collision.
    always_ff @(posedge clk_core_i) begin
        if (ld_we_i) begin
            mem_r[ld_addr_i] <= ld_data_i;
        end
        if (spi_we_s && !(ld_we_i && (ld_addr_i == addr_r))) begin
            mem_r[addr_r] <= rx_byte_s;
        end
    end

    assign spi.spi_miso_o = miso_r;
    assign busy_o         = busy_r;
    assign cmd_err_o      = cmd_err_r;

endmodule

// File: tb/tb_spi_mem_slave.sv
// Self-checking bench for spi_mem_slave: bit-banged SPI master, loader stimulus and a
// byte scoreboard fed from a bench-side memory model. Covers SPI_MEM_WP_EN when defined.
module tb_spi_mem_slave;
    localparam int DEPTH = 256;
    localparam int HALF  = 8;

    logic       clk_core_i = 1'b0;
    logic       rst_n_i    = 1'b0;
    logic       ld_we      = 1'b0;
    logic [7:0] ld_addr    = 8'h00;
    logic [7:0] ld_data    = 8'h00;
    logic       busy, cmd_err;
`ifdef SPI_MEM_WP_EN
    logic       wp_n       = 1'b1;
`endif

    spi_mem_slave_if spi_if();

    spi_mem_slave #(.DEPTH(DEPTH)) dut (
        .clk_core_i (clk_core_i),
        .rst_n_i    (rst_n_i),
        .spi        (spi_if.slave),
        .ld_we_i    (ld_we),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
`ifdef SPI_MEM_WP_EN
        .wp_n_i     (wp_n),
`endif
        .busy_o     (busy),
        .cmd_err_o  (cmd_err)
    );

    always #5 clk_core_i = ~clk_core_i;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         err_cycles = 0;
    logic [7:0] model_mem [DEPTH];
    logic [7:0] exp_q [$];

    // Counts every clock cycle in which cmd_err_o is high.
    always @(posedge clk_core_i) begin
        if (cmd_err === 1'b1) err_cycles <= err_cycles + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_core_i);
    endtask

    function automatic logic wp_ok();
`ifdef SPI_MEM_WP_EN
        return wp_n;
`else
        return 1'b1;
`endif
    endfunction

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk_core_i);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk_core_i);
        ld_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_if.spi_mosi_i = tx[i];
            wait_cyc(HALF);
            rx[i] = spi_if.spi_miso_o;
            spi_if.spi_sclk_i = 1'b1;
            wait_cyc(HALF);
            spi_if.spi_sclk_i = 1'b0;
        end
    endtask

    task automatic cs_start();
        spi_if.spi_cs_i = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic cs_end();
        wait_cyc(HALF);
        spi_if.spi_cs_i = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic spi_read(input logic [15:0] a, input int n, input string tag);
        logic [7:0] rx;
        cs_start();
        spi_xfer(8'h03, 8, rx);
        spi_xfer(a[15:8], 8, rx);
        spi_xfer(a[7:0], 8, rx);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model_mem[(int'(a[7:0]) + k) % DEPTH]);
            spi_xfer(8'h00, 8, rx);
            chk(tag, {24'd0, rx}, {24'd0, exp_q.pop_front()});
        end
        cs_end();
    endtask

    task automatic spi_write(input logic [15:0] a, input logic [7:0] d0,
                             input logic [7:0] d1, input int n);
        logic [7:0] rx;
        logic [7:0] d;
        cs_start();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(a[15:8], 8, rx);
        spi_xfer(a[7:0], 8, rx);
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : d1;
            spi_xfer(d, 8, rx);
            if (wp_ok()) model_mem[(int'(a[7:0]) + k) % DEPTH] = d;
        end
        cs_end();
    endtask

    initial begin
        logic [7:0] rx;
        int e0;
        spi_if.spi_cs_i   = 1'b1;
        spi_if.spi_sclk_i = 1'b0;
        spi_if.spi_mosi_i = 1'b0;

        wait_cyc(5);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_miso", {31'd0, spi_if.spi_miso_o}, 32'd0);
        chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        rst_n_i = 1'b1;
        wait_cyc(6);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Loader preload then read back with one dummy byte.
        load(8'h10, 8'hA5);
        spi_read(16'h0010, 1, "t1_rd_a5");

        // Two-byte write burst, then burst and single read-back.
        spi_write(16'h0020, 8'h11, 8'h22, 2);
        spi_read(16'h0020, 2, "t2_rd_burst");
        spi_read(16'h0021, 1, "t2_rd_21");

        // Write across the top of the array.
        spi_write(16'h00FF, 8'h5A, 8'h6B, 2);
        spi_read(16'h00FF, 2, "t3_wrap_rd");

        // Read burst wraps too; address bits above AW are ignored.
        load(8'hFE, 8'hC3);
        spi_read(16'h00FE, 3, "rd_wrap_burst");
        spi_read(16'h0110, 1, "hi_addr_ignored");

        // Unsupported opcode: single error pulse, MISO low, trailing WRITE bytes ignored.
        e0 = err_cycles;
        cs_start();
        spi_xfer(8'h9F, 8, rx);
        chk("t4_err_pulse", err_cycles - e0, 32'd1);
        spi_xfer(8'h02, 8, rx);
        chk("t4_miso_b1", {24'd0, rx}, 32'd0);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h10, 8, rx);
        spi_xfer(8'h55, 8, rx);
        chk("t4_miso_b4", {24'd0, rx}, 32'd0);
        cs_end();
        chk("t4_err_total", err_cycles - e0, 32'd1);
        spi_read(16'h0010, 1, "t4_mem_kept");

        // Partial byte aborted by CS release; then a full write still works.
        load(8'h30, 8'h3C);
        cs_start();
        wait_cyc(2);
        chk("t5_busy_hi", {31'd0, busy}, 32'd1);
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h30, 8, rx);
        spi_xfer(8'hFF, 5, rx);
        wait_cyc(HALF);
        spi_if.spi_cs_i = 1'b1;
        wait_cyc(2 * HALF);
        chk("t5_busy_lo", {31'd0, busy}, 32'd0);
        spi_read(16'h0030, 1, "t5_mem_kept");
        spi_write(16'h0030, 8'h99, 8'h00, 1);
        spi_read(16'h0030, 1, "t5_rewrite");

        // Reset mid-transfer with CS held low: following bytes must be ignored.
        load(8'h50, 8'h5E);
        e0 = err_cycles;
        cs_start();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h50, 8, rx);
        @(negedge clk_core_i);
        rst_n_i = 1'b0;
        wait_cyc(3);
        rst_n_i = 1'b1;
        wait_cyc(4);
        spi_xfer(8'hEE, 8, rx);
        cs_end();
        chk("rst_abort_noerr", err_cycles - e0, 32'd0);
        spi_read(16'h0050, 1, "rst_abort_mem");

`ifdef SPI_MEM_WP_EN
        load(8'h40, 8'h01);
        wp_n = 1'b0;
        spi_write(16'h0040, 8'h77, 8'h00, 1);
        spi_read(16'h0040, 1, "t6_wp_blocked");
        wp_n = 1'b1;
        spi_write(16'h0040, 8'h77, 8'h00, 1);
        spi_read(16'h0040, 1, "t6_wp_released");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
